// File: rtl/jtframe_sdram_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | jtframe_sdram_arb_pkg                                                |
// | Shared types and default widths for the SDRAM ROM-slot arbiter.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package jtframe_sdram_arb_pkg;

   localparam int DEF_AW = 22;
   localparam int DEF_DW = 32;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_ACK = 2'd1,
      WAIT_RDY = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/jtframe_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | jtframe_rr_pick                                                      |
// | Combinational round-robin picker: rotate the request vector so the   |
// | slot after 'last' sits at bit 0, take the lowest set bit, and map    |
// | the result back to an absolute slot index.                           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module jtframe_rr_pick #(
   parameter int N  = 4,
   parameter int LW = $clog2(N)
)(
   input  logic [N-1:0]  req,
   input  logic [LW-1:0] last,
   output logic          any,
   output logic [LW-1:0] gnt
);

   logic [N-1:0]  rot;
   logic [LW-1:0] start;
   logic [LW-1:0] offs;
   int            idx;
   int            sum;

   // Rotate, priority-encode and unrotate in one combinational pass
   always_comb begin
      start = (int'(last) >= N-1) ? '0 : last + 1'b1;
      rot   = '0;
      idx   = 0;
      for (int k = 0; k < N; k++) begin
         idx = int'(start) + k;
         if (idx >= N) idx = idx - N;
         rot[k] = req[idx];
      end
      any  = |req;
      offs = '0;
      for (int k = N-1; k >= 0; k--) begin
         if (rot[k]) offs = LW'(k);
      end
      sum = int'(start) + int'(offs);
      if (sum >= N) sum = sum - N;
      gnt = LW'(sum);
   end

endmodule
`default_nettype wire

// File: rtl/jtframe_sdram_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | jtframe_sdram_arb                                                    |
// | Shares one SDRAM read port between SLOTS ROM requesters. Each slot   |
// | owns a one-word tag cache; only misses generate SDRAM traffic.       |
// | Grants are round-robin, refresh is allowed while idle, and the ROM   |
// | download invalidates the caches and blocks new grants.               |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module jtframe_sdram_arb
   import jtframe_sdram_arb_pkg::*;
#(
   parameter int SLOTS = 4,
   parameter int AW    = DEF_AW,
   parameter int DW    = DEF_DW
)(
   input  logic                clk,
   input  logic                rst,
   input  logic                downloading,
   input  logic [SLOTS-1:0]    slot_cs,
   input  logic [SLOTS*AW-1:0] slot_addr,
   output logic [SLOTS-1:0]    slot_ok,
   output logic [SLOTS*DW-1:0] slot_dout,
   output logic                sdram_req,
   output logic [AW-1:0]       sdram_addr,
   input  logic                sdram_ack,
   input  logic                data_rdy,
   input  logic [DW-1:0]       data_read,
   output logic                refresh_en
);

   localparam int LW = $clog2(SLOTS);

   state_t            state;
   state_t            state_nx;
   logic [SLOTS-1:0]  valid;
   logic [SLOTS-1:0]  hit;
   logic [SLOTS-1:0]  pending;
   logic [AW-1:0]     tag  [SLOTS];
   logic [DW-1:0]     data [SLOTS];
   logic [LW-1:0]     last_grant;
   logic [LW-1:0]     gnt;
   logic [LW-1:0]     pick;
   logic              pick_any;
   logic              grant_now;
   logic              store;
   logic              discard;
   logic [AW-1:0]     cap_addr;
   logic [AW-1:0]     pick_addr;

   // Per-slot hit detection and cache outputs
   for (genvar i = 0; i < SLOTS; i++) begin : g_slot
      assign hit[i]                 = valid[i] & (tag[i] == slot_addr[i*AW +: AW]);
      assign pending[i]             = slot_cs[i] & ~hit[i];
      assign slot_ok[i]             = slot_cs[i] & hit[i];
      assign slot_dout[i*DW +: DW]  = data[i];
   end

   jtframe_rr_pick #(
      .N    (SLOTS),
      .LW   (LW)
   ) u_pick (
      .req  (pending),
      .last (last_grant),
      .any  (pick_any),
      .gnt  (pick)
   );

   assign pick_addr = slot_addr[int'(pick)*AW +: AW];

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next state, grant and cache-store decisions
   always_comb begin
      state_nx  = state;
      grant_now = 1'b0;
      store     = 1'b0;
      case (state)
         IDLE: begin
            if (!downloading && pick_any) begin
               grant_now = 1'b1;
               state_nx  = WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            // ack and rdy together complete the whole transaction at once
            if (sdram_ack) begin
               if (data_rdy) begin
                  store    = 1'b1;
                  state_nx = IDLE;
               end else begin
                  state_nx = WAIT_RDY;
               end
            end
         end
         WAIT_RDY: begin
            if (data_rdy) begin
               store    = 1'b1;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Request port, cache contents, refresh permission and discard flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sdram_req  <= 1'b0;
         sdram_addr <= '0;
         cap_addr   <= '0;
         gnt        <= '0;
         last_grant <= LW'(SLOTS-1);
         refresh_en <= 1'b1;
         discard    <= 1'b0;
         valid      <= '0;
         for (int i = 0; i < SLOTS; i++) begin
            tag[i]  <= '0;
            data[i] <= '0;
         end
      end else begin
         if (grant_now) begin
            sdram_req  <= 1'b1;
            sdram_addr <= pick_addr;
            cap_addr   <= pick_addr;
            gnt        <= pick;
            last_grant <= pick;
         end
         if (state == WAIT_ACK && sdram_ack) sdram_req <= 1'b0;

         refresh_en <= (state == IDLE) && !grant_now;

         if (state == IDLE)    discard <= 1'b0;
         else if (downloading) discard <= 1'b1;

         // The captured address becomes the tag so a mid-fetch address
         // change can never be reported as a hit on the wrong word
         if (store) begin
            data[gnt]  <= data_read;
            tag[gnt]   <= cap_addr;
            valid[gnt] <= ~(discard | downloading);
         end

         if (downloading) valid <= '0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_jtframe_sdram_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_jtframe_sdram_arb                                                 |
// | Directed scenarios followed by a randomized run, all checked against |
// | a transaction-level model of the slot caches and the arbiter.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_jtframe_sdram_arb;

   localparam int SLOTS = 4;
   localparam int AW    = 22;
   localparam int DW    = 32;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                downloading = 1'b0;
   logic [SLOTS-1:0]    slot_cs = '0;
   logic [AW-1:0]       a [SLOTS];
   logic [SLOTS*AW-1:0] slot_addr;
   logic [SLOTS-1:0]    slot_ok;
   logic [SLOTS*DW-1:0] slot_dout;
   logic                sdram_req;
   logic [AW-1:0]       sdram_addr;
   logic                sdram_ack = 1'b0;
   logic                data_rdy = 1'b0;
   logic [DW-1:0]       data_read = '0;
   logic                refresh_en;

   int checks = 0;
   int errors = 0;

   // model state
   logic [SLOTS-1:0] mvalid;
   logic [AW-1:0]    mtag  [SLOTS];
   logic [DW-1:0]    mdata [SLOTS];
   int               mlast, mgnt;
   logic             mbusy, macked, mdiscard, mreq, mref;
   logic [AW-1:0]    mcap, maddr;

   // controller emulation
   int            phase = 0;
   int            cnt = 0;
   int            ack_dly = 0;
   int            rdy_dly = 1;
   logic          rand_mode = 1'b0;
   logic          stray = 1'b0;
   logic          rdy_now = 1'b0;
   logic          prev_req = 1'b0;
   logic [AW-1:0] req_a = '0;
   int            nreq = 0;
   logic [AW-1:0] req_log [$];

   always #5 clk = ~clk;

   always_comb begin
      for (int i = 0; i < SLOTS; i++) slot_addr[i*AW +: AW] = a[i];
   end

   jtframe_sdram_arb #(.SLOTS(SLOTS), .AW(AW), .DW(DW)) dut (
      .clk         (clk),
      .rst         (rst),
      .downloading (downloading),
      .slot_cs     (slot_cs),
      .slot_addr   (slot_addr),
      .slot_ok     (slot_ok),
      .slot_dout   (slot_dout),
      .sdram_req   (sdram_req),
      .sdram_addr  (sdram_addr),
      .sdram_ack   (sdram_ack),
      .data_rdy    (data_rdy),
      .data_read   (data_read),
      .refresh_en  (refresh_en)
   );

   function automatic logic [DW-1:0] memfn(input logic [AW-1:0] ad);
      if (ad == 22'h00123) return 32'hDEADBEEF;
      return {ad[9:0], ad} ^ 32'h5A5A0F0F;
   endfunction

   function automatic logic [SLOTS-1:0] mhit();
      logic [SLOTS-1:0] r;
      for (int i = 0; i < SLOTS; i++) r[i] = mvalid[i] && (mtag[i] == a[i]);
      return r;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mvalid = '0;
      for (int i = 0; i < SLOTS; i++) begin mtag[i] = '0; mdata[i] = '0; end
      mlast = SLOTS-1; mgnt = 0;
      mbusy = 0; macked = 0; mdiscard = 0; mreq = 0; mref = 1;
      mcap = '0; maddr = '0;
   endtask

   // One clock: drive the controller, advance the model across the edge,
   // then compare every output at the falling edge.
   task automatic tick();
      logic [SLOTS-1:0] pend;
      logic grant, nref, store;
      int g;
      sdram_ack = 1'b0;
      data_rdy  = stray;
      data_read = $urandom;
      if (phase == 1) begin
         if (cnt == 0) begin
            sdram_ack = 1'b1;
            if (rdy_dly == 0) begin
               data_rdy = 1'b1; data_read = memfn(req_a); phase = 0;
            end else begin
               phase = 2; cnt = rdy_dly - 1;
            end
         end else cnt--;
      end else if (phase == 2) begin
         if (cnt == 0) begin
            data_rdy = 1'b1; data_read = memfn(req_a); phase = 0;
         end else cnt--;
      end
      rdy_now = data_rdy && !stray;

      pend  = slot_cs & ~mhit();
      grant = !mbusy && !downloading && (pend != '0);
      nref  = !mbusy && !grant;
      if (mbusy) begin
         store = data_rdy && (macked || sdram_ack);
         if (!macked && sdram_ack) begin macked = 1; mreq = 0; end
         if (store) begin
            mdata[mgnt]  = data_read;
            mtag[mgnt]   = mcap;
            mvalid[mgnt] = !(mdiscard || downloading);
            mbusy = 0; mdiscard = 0;
         end else if (downloading) mdiscard = 1;
      end
      if (grant) begin
         g = -1;
         for (int k = 1; k <= SLOTS; k++) begin
            int j;
            j = (mlast + k) % SLOTS;
            if (g < 0 && pend[j]) g = j;
         end
         mgnt = g; mlast = g; mbusy = 1; macked = 0; mreq = 1;
         maddr = a[g]; mcap = a[g];
      end
      if (downloading) mvalid = '0;
      mref = nref;

      @(posedge clk);
      @(negedge clk);

      chk("slot_ok", slot_ok, slot_cs & mhit());
      for (int i = 0; i < SLOTS; i++) begin
         chk($sformatf("dout%0d", i), slot_dout[i*DW +: DW], mdata[i]);
         if (slot_ok[i]) chk($sformatf("ok_word%0d", i), slot_dout[i*DW +: DW], memfn(a[i]));
      end
      chk("sdram_req", sdram_req, mreq);
      chk("sdram_addr", sdram_addr, maddr);
      chk("refresh_en", refresh_en, mref);

      if (sdram_req && !prev_req) begin
         nreq++;
         req_log.push_back(sdram_addr);
         req_a = sdram_addr;
         if (rand_mode) begin
            ack_dly = $urandom_range(0, 3);
            rdy_dly = $urandom_range(0, 4);
         end
         phase = 1; cnt = ack_dly;
      end
      prev_req = sdram_req;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      sdram_ack = 1'b0; data_rdy = 1'b0;
      @(posedge clk);
      @(negedge clk);
      model_reset();
      phase = 0; prev_req = 1'b0;
      rst = 1'b0;
   endtask

   task automatic wait_req(input string tag, input int bound);
      int start = nreq;
      for (int k = 0; k < bound && nreq == start; k++) tick();
      chk({tag, "_req_seen"}, nreq != start, 1);
   endtask

   task automatic wait_rdy(input string tag, input int bound);
      rdy_now = 1'b0;
      for (int k = 0; k < bound && !rdy_now; k++) tick();
      chk({tag, "_rdy_seen"}, rdy_now, 1);
   endtask

   task automatic wait_phase2(input string tag, input int bound);
      for (int k = 0; k < bound && phase != 2; k++) tick();
      chk({tag, "_in_wait_rdy"}, phase == 2, 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "simulation did not terminate");
   end

   initial begin
      int n0;
      for (int i = 0; i < SLOTS; i++) a[i] = '0;
      model_reset();

      // reset state
      do_reset();
      chk("rst_refresh_en", refresh_en, 1);
      chk("rst_sdram_req", sdram_req, 0);
      chk("rst_sdram_addr", sdram_addr, 0);
      chk("rst_slot_ok", slot_ok, 0);
      tick();

      // single miss on slot 1
      a[1] = 22'h00123; slot_cs = 4'b0010;
      ack_dly = 2; rdy_dly = 4;
      wait_req("miss", 10);
      chk("miss_addr", sdram_addr, 22'h00123);
      wait_rdy("miss", 20);
      chk("miss_ok", slot_ok[1], 1);
      chk("miss_dout", slot_dout[1*DW +: DW], 32'hDEADBEEF);
      n0 = nreq;
      repeat (5) tick();
      chk("miss_no_second_req", nreq, n0);
      chk("miss_req_low", sdram_req, 0);

      // hit on the same word
      slot_cs = 4'b0000;
      tick();
      slot_cs = 4'b0010; a[1] = 22'h00123;
      #1;
      chk("hit_ok_same_cycle", slot_ok[1], 1);
      chk("hit_no_req", sdram_req, 0);
      repeat (3) tick();
      chk("hit_no_traffic", nreq, n0);

      // round robin from reset
      do_reset();
      req_log.delete();
      a[0] = 22'h10; a[1] = 22'h20; a[2] = 22'h30; a[3] = 22'h40;
      slot_cs = 4'b1111; ack_dly = 0; rdy_dly = 1;
      for (int k = 0; k < 60 && req_log.size() < 4; k++) tick();
      chk("rr_count4", req_log.size(), 4);
      if (req_log.size() >= 4) begin
         chk("rr_g0", req_log[0], 22'h10);
         chk("rr_g1", req_log[1], 22'h20);
         chk("rr_g2", req_log[2], 22'h30);
         chk("rr_g3", req_log[3], 22'h40);
      end
      slot_cs = 4'b0101; a[0] = 22'h50; a[2] = 22'h60;
      for (int k = 0; k < 60 && req_log.size() < 6; k++) tick();
      chk("rr_count6", req_log.size(), 6);
      if (req_log.size() >= 6) begin
         chk("rr_g4", req_log[4], 22'h50);
         chk("rr_g5", req_log[5], 22'h60);
      end
      repeat (6) tick();

      // address change mid-fetch
      slot_cs = 4'b0001; a[0] = 22'h100; ack_dly = 0; rdy_dly = 3;
      wait_req("achg", 10);
      chk("achg_addr1", sdram_addr, 22'h100);
      wait_phase2("achg", 10);
      a[0] = 22'h200;
      wait_rdy("achg", 10);
      chk("achg_ok_after_rdy", slot_ok[0], 0);
      wait_req("achg2", 10);
      chk("achg_addr2", sdram_addr, 22'h200);
      a[0] = 22'h100;
      #1;
      chk("achg_stale_tag_ok", slot_ok[0], 1);
      chk("achg_stale_dout", slot_dout[0 +: DW], memfn(22'h100));
      a[0] = 22'h200;
      wait_rdy("achg2", 10);
      chk("achg_ok_new", slot_ok[0], 1);
      chk("achg_dout_new", slot_dout[0 +: DW], memfn(22'h200));

      // download during a fetch
      slot_cs = 4'b0010; a[1] = 22'h300; ack_dly = 0; rdy_dly = 4;
      wait_req("dl", 10);
      wait_phase2("dl", 10);
      downloading = 1'b1;
      wait_rdy("dl", 10);
      chk("dl_ok_after_rdy", slot_ok, 0);
      n0 = nreq;
      repeat (6) tick();
      chk("dl_no_req", nreq, n0);
      chk("dl_req_low", sdram_req, 0);
      downloading = 1'b0;
      a[0] = 22'h200; a[1] = 22'h300; a[2] = 22'h60; a[3] = 22'h40;
      slot_cs = 4'b1111; ack_dly = 1; rdy_dly = 1;
      for (int k = 0; k < 80 && nreq < n0 + 4; k++) tick();
      chk("dl_rerequest_all", nreq - n0, 4);
      repeat (6) tick();

      // reset in the middle of a transaction
      slot_cs = 4'b0001; a[0] = 22'h700; ack_dly = 3;
      wait_req("rstop", 10);
      rst = 1'b1;
      #1;
      chk("rstop_req", sdram_req, 0);
      chk("rstop_refresh", refresh_en, 1);
      chk("rstop_ok", slot_ok, 0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0; phase = 0; prev_req = 1'b0;
      slot_cs = 4'b0000;
      stray = 1'b1;
      tick();
      stray = 1'b0;
      chk("stray_req", sdram_req, 0);
      chk("stray_dout0", slot_dout[0 +: DW], 0);
      chk("stray_refresh", refresh_en, 1);
      tick();

      // randomized traffic
      rand_mode = 1'b1;
      for (int c = 0; c < 500; c++) begin
         for (int i = 0; i < SLOTS; i++) begin
            if ($urandom_range(0, 5) == 0) slot_cs[i] = ~slot_cs[i];
            if ($urandom_range(0, 5) == 0) a[i] = AW'(22'h1000 * (i + 1) + $urandom_range(0, 5));
         end
         if (downloading) begin
            if ($urandom_range(0, 3) == 0) downloading = 1'b0;
         end else if ($urandom_range(0, 39) == 0) downloading = 1'b1;
         tick();
      end
      downloading = 1'b0;
      repeat (20) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/jtframe_sdram_arb.md
Name: jtframe_sdram_arb

Overview:
- Shares the single game-side SDRAM read port (sdram_req/sdram_addr/sdram_ack/data_rdy/data_read) between SLOTS ROM requesters (CPU ROM, tiles, sprites, sound ROM).
- Each slot gets a one-entry tag cache, so repeat reads of the same word return with no SDRAM traffic.
- Sits between the game core's ROM slots and the frame's SDRAM controller.
- Also drives refresh_en and blocks all traffic while the ROM download is active.

Parameters:
- SLOTS, 4, number of requesters (2..8).
- AW, 22, SDRAM word-address width.
- DW, 32, SDRAM read-data width.

Ports:
- clk  in  1  system/ROM clock.
- rst  in  1  asynchronous, active-high reset.
- downloading  in  1  ROM download in progress; blocks new grants.
- slot_cs  in  SLOTS  per-slot read request (level).
- slot_addr  in  SLOTS*AW  packed per-slot word addresses; slot i at [i*AW +: AW].
- slot_ok  out  SLOTS  data valid for the slot's current address.
- slot_dout  out  SLOTS*DW  packed per-slot cached data.
- sdram_req  out  1  request to the SDRAM controller.
- sdram_addr  out  AW  request address.
- sdram_ack  in  1  controller accepted the request.
- data_rdy  in  1  one-cycle pulse; data_read is valid.
- data_read  in  DW  SDRAM read data.
- refresh_en  out  1  controller may refresh.

Behaviour:
- Reset values: state=IDLE; sdram_req=0; sdram_addr=0; refresh_en=1; all valid=0; all tags=0; all data=0; last_grant=SLOTS-1, so slot 0 wins first.
- hit[i] = valid[i] & (tag[i]==slot_addr[i]). slot_ok[i] = slot_cs[i] & hit[i], combinational from registers. slot_dout[i] = data[i], always driven.
- pending[i] = slot_cs[i] & ~hit[i].
- IDLE:
  - If downloading=0 and pending≠0: grant g = first pending slot in round-robin order last_grant+1 … last_grant+SLOTS (mod SLOTS).
  - Register sdram_req=1, sdram_addr=slot_addr[g], cap_addr=slot_addr[g], gnt=g, last_grant=g. Go to WAIT_ACK.
- WAIT_ACK: hold sdram_req and sdram_addr stable. On sdram_ack, set sdram_req=0 and go to WAIT_RDY.
- WAIT_RDY: on data_rdy, set data[gnt]=data_read, tag[gnt]=cap_addr, valid[gnt]=~discard. Go to IDLE.
- An ack and a rdy in the same cycle in WAIT_ACK count as both: the data is stored and the FSM returns to IDLE.
- Miss latency:
  - slot_ok rises no earlier than the cycle after data_rdy.
  - Minimum request-to-ok time is 3 cycles plus controller latency.
  - A new grant can issue in the cycle after data_rdy.
- The captured address is stored as the tag, not the live address. If a slot changes address mid-fetch, the stale tag misses and the slot requests again. A slot is never given ok for the wrong word.
- slot_cs dropping mid-fetch does not abort the SDRAM transaction. It completes and fills the cache.
- downloading=1:
  - Clears all valid bits every cycle and blocks new grants.
  - A transaction already in flight runs to data_rdy with discard=1, so its data is not marked valid.
  - discard is set when downloading is seen during WAIT_ACK/WAIT_RDY and cleared on return to IDLE.
- refresh_en = 1 in IDLE with no grant this cycle; 0 otherwise. Registered.
- Fairness: with all slots pending continuously, each slot is granted once every SLOTS transactions.
- Asynchronous reset mid-transaction returns to IDLE immediately. Any late ack or rdy from the controller is ignored in IDLE.

Decomposition:
- Package jtframe_sdram_arb_pkg: state enum (IDLE, WAIT_ACK, WAIT_RDY) and default AW/DW localparams.
- One sub-module: jtframe_rr_pick.
  - Parameter N.
  - Inputs req[N] and last[$clog2(N)].
  - Outputs any and gnt index.
  - Purely combinational rotate, priority-encode, unrotate.

Test Plan:
- Single miss: slot 1 cs=1, addr=0x00123; controller acks 2 cycles later and rdy 4 cycles after that with data 0xDEADBEEF. Required: sdram_addr=0x00123; slot_ok[1]=1 with dout 0xDEADBEEF the cycle after rdy; no second request.
- Hit: the same slot re-requests 0x00123 later. Required: slot_ok[1]=1 in the same cycle and sdram_req stays 0.
- Round robin: slots 0–3 all pending from reset, with distinct addresses. Required: grant order 0,1,2,3. Then keep slots 0 and 2 pending with new addresses after the last grant (3); required next order 0,2.
- Address change mid-fetch: slot 0 switches from 0x100 to 0x200 while in WAIT_RDY. Required: tag=0x100 and slot_ok[0]=0 after rdy, then a new request to 0x200.
- Download: raise downloading during WAIT_RDY. Required: after rdy, valid stays 0 and no sdram_req while downloading=1. After it drops, all slots miss and re-request.
- Reset mid-op: assert rst during WAIT_ACK. Required: sdram_req=0, refresh_en=1, all slot_ok=0 immediately, and a stray data_rdy changes nothing.
